// File: rtl/trigger_channel_bank_if.sv
// trigger_channel_bank_if: BSYNC/trigger inputs, armed configuration and status of the trigger bank
interface trigger_channel_bank_if #(
    parameter int CHANNEL_COUNT = 4,
    parameter int PHASE_WIDTH   = 16,
    parameter int BURST_WIDTH   = 8,
    parameter int PW_WIDTH      = 4
);
    logic                                 bsync;
    logic                                 bsync_ready;
    logic                                 trigger;
    logic                                 arm;
    logic                                 disarm;
    logic [1:0]                           mode;
    logic [BURST_WIDTH-1:0]               burst_count;
    logic [PW_WIDTH-1:0]                  pulse_width;
    logic [CHANNEL_COUNT-1:0]             ch_en;
    logic [CHANNEL_COUNT*PHASE_WIDTH-1:0] ch_phase;
    logic                                 err_clear;
    logic [CHANNEL_COUNT-1:0]             trig_out;
    logic [2:0]                           state;
    logic                                 busy;
    logic                                 done;
    logic                                 overrun_err;
    logic                                 sync_lost_err;

    modport master (
        output bsync, bsync_ready, trigger, arm, disarm, mode, burst_count, pulse_width,
               ch_en, ch_phase, err_clear,
        input  trig_out, state, busy, done, overrun_err, sync_lost_err
    );

    modport slave (
        input  bsync, bsync_ready, trigger, arm, disarm, mode, burst_count, pulse_width,
               ch_en, ch_phase, err_clear,
        output trig_out, state, busy, done, overrun_err, sync_lost_err
    );
endinterface

// File: rtl/trigger_channel_bank.sv
// trigger_channel_bank: BSYNC-aligned multi-channel trigger generator (single/burst/continuous).
// Optional TRIGGER_CHANNEL_BANK_TIMESTAMP_EN adds trig_timestamp, the BSYNC count at trigger acceptance.
module trigger_channel_bank #(
    parameter int CHANNEL_COUNT = 4,
    parameter int PHASE_WIDTH   = 16,
    parameter int BURST_WIDTH   = 8,
    parameter int PW_WIDTH      = 4
) (
    input logic                   clk,
    input logic                   rstn,
    trigger_channel_bank_if.slave bus
`ifdef TRIGGER_CHANNEL_BANK_TIMESTAMP_EN
    ,
    output logic [31:0]           trig_timestamp
`endif
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARMED      = 3'd1,
        WAIT_BSYNC = 3'd2,
        RUN        = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t                               st, nxt;
    logic                                 trig_q;
    logic [1:0]                           mode_r;
    logic [BURST_WIDTH-1:0]               bc_r;
    logic [PW_WIDTH-1:0]                  pw_r;
    logic [CHANNEL_COUNT-1:0]             en_r;
    logic [CHANNEL_COUNT*PHASE_WIDTH-1:0] ph_r;
    logic [BURST_WIDTH:0]                 ep;
    logic [CHANNEL_COUNT-1:0]             fired, high, fire;
    logic                                 edge_ok, abort, lost, remain, start, finished, ov_set;
    logic                                 busy_r, done_r, ov_r, sl_r;

    // event decode and next-state selection; disarm and BSYNC loss override everything
    always_comb begin
        edge_ok  = bus.trigger && !trig_q;
        abort    = st != IDLE && (bus.disarm || !bus.bsync_ready);
        lost     = !bus.disarm && !bus.bsync_ready && (st == WAIT_BSYNC || st == RUN);
        remain   = mode_r == 2'd2 || (mode_r == 2'd1 && ep < {1'b0, bc_r});
        start    = !abort && bus.bsync && (st == WAIT_BSYNC || (st == RUN && remain));
        finished = &(fired | ~en_r) && high == '0 && (!remain || en_r == '0);
        ov_set   = start && st == RUN && |(en_r & ~fired);
        nxt      = st;
        if (abort) nxt = IDLE;
        else begin
            case (st)
                IDLE:       nxt = bus.arm && bus.bsync_ready ? ARMED : IDLE;
                ARMED:      nxt = edge_ok ? WAIT_BSYNC : ARMED;
                WAIT_BSYNC: nxt = bus.bsync ? RUN : WAIT_BSYNC;
                RUN:        nxt = finished ? DONE : RUN;
                default:    nxt = IDLE;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) st <= IDLE;
        else st <= nxt;
    end

    // trigger edge history, configuration snapshot, epoch counter and status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_q <= 1'b0;
            mode_r <= '0;
            bc_r   <= '0;
            pw_r   <= '0;
            en_r   <= '0;
            ph_r   <= '0;
            ep     <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ov_r   <= 1'b0;
            sl_r   <= 1'b0;
        end else begin
            trig_q <= bus.trigger;
            if (st == IDLE && bus.arm && bus.bsync_ready) begin
                mode_r <= bus.mode;
                bc_r   <= bus.burst_count;
                pw_r   <= bus.pulse_width;
                en_r   <= bus.ch_en;
                ph_r   <= bus.ch_phase;
            end
            if (start) ep <= st == WAIT_BSYNC ? '0 : (&ep ? ep : ep + 1'b1);
            busy_r <= nxt != IDLE;
            done_r <= nxt == DONE;
            ov_r   <= ov_set || (ov_r && !bus.err_clear);
            sl_r   <= lost || (sl_r && !bus.err_clear);
        end
    end

    for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
        logic [PHASE_WIDTH-1:0] cnt, cnt_nxt;
        logic [PW_WIDTH-1:0]    wcnt;
        logic                   fired_q, high_q;
        assign cnt_nxt  = start ? '0 : (&cnt ? cnt : cnt + 1'b1);
        assign fire[i]  = (start || (st == RUN && !abort)) && en_r[i] && (start || !fired_q) &&
                          cnt_nxt == ph_r[i*PHASE_WIDTH +: PHASE_WIDTH];
        assign fired[i] = fired_q;
        assign high[i]  = high_q;
        // phase counter, once-per-epoch flag and pulse stretcher for one channel
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt     <= '0;
                wcnt    <= '0;
                fired_q <= 1'b0;
                high_q  <= 1'b0;
            end else if (abort) begin
                cnt     <= '0;
                wcnt    <= '0;
                fired_q <= 1'b0;
                high_q  <= 1'b0;
            end else begin
                if (start || st == RUN) cnt <= cnt_nxt;
                fired_q <= fire[i] || (fired_q && !start);
                if (fire[i]) begin
                    high_q <= 1'b1;
                    wcnt   <= '0;
                end else if (high_q) begin
                    if (wcnt == pw_r) high_q <= 1'b0;
                    else wcnt <= wcnt + 1'b1;
                end
            end
        end
    end

`ifdef TRIGGER_CHANNEL_BANK_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // free-running BSYNC count, captured when ARMED accepts the trigger edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ts_cnt         <= '0;
            trig_timestamp <= '0;
        end else begin
            if (bus.bsync) ts_cnt <= ts_cnt + 1'b1;
            if (st == ARMED && !abort && edge_ok) trig_timestamp <= ts_cnt;
        end
    end
`endif

    assign bus.trig_out      = high;
    assign bus.state         = st;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.overrun_err   = ov_r;
    assign bus.sync_lost_err = sl_r;
endmodule

// File: tb/tb_trigger_channel_bank.sv
// tb_trigger_channel_bank: time-based reference model plus directed literal checks for trigger_channel_bank
module tb_trigger_channel_bank;
    localparam int CC = 4, PHW = 16, BW = 8, PWW = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0, errors = 0, nprint = 0;

    always #5 clk = ~clk;

    trigger_channel_bank_if #(.CHANNEL_COUNT(CC), .PHASE_WIDTH(PHW), .BURST_WIDTH(BW), .PW_WIDTH(PWW)) bus ();

`ifdef TRIGGER_CHANNEL_BANK_TIMESTAMP_EN
    logic [31:0] ts;
    trigger_channel_bank #(.CHANNEL_COUNT(CC), .PHASE_WIDTH(PHW), .BURST_WIDTH(BW), .PW_WIDTH(PWW)) dut (
        .clk(clk), .rstn(rstn), .bus(bus.slave), .trig_timestamp(ts));
`else
    trigger_channel_bank #(.CHANNEL_COUNT(CC), .PHASE_WIDTH(PHW), .BURST_WIDTH(BW), .PW_WIDTH(PWW)) dut (
        .clk(clk), .rstn(rstn), .bus(bus.slave));
`endif

    // reference model: channel pulses expressed as absolute rise times
    longint cyc = 0, t_ep = 0;
    longint rise [CC];
    int ms = 0, mbc = 0, mpw = 0, mep = 0;
    int mph [CC];
    logic [1:0] mm = '0;
    logic [CC-1:0] men = '0, pend = '0;
    logic mprev = 1'b0, mov = 1'b0, msl = 1'b0;
    logic [31:0] mts_cnt = '0, mts = '0;
    logic [CC-1:0] e_trig = '0;
    logic [2:0] e_state = '0;
    logic e_busy = 1'b0, e_done = 1'b0, e_ov = 1'b0, e_sl = 1'b0;

    function automatic logic hi(input int i, input longint c);
        return rise[i] >= 0 && c >= rise[i] && c <= rise[i] + mpw;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ms = 0; mm = '0; mbc = 0; mpw = 0; mep = 0; men = '0; pend = '0;
            mprev = 1'b0; mov = 1'b0; msl = 1'b0; mts_cnt = '0; mts = '0;
            for (int i = 0; i < CC; i++) begin rise[i] = -1; mph[i] = 0; end
            e_trig = '0; e_state = '0; e_busy = 1'b0; e_done = 1'b0; e_ov = 1'b0; e_sl = 1'b0;
        end else begin
            automatic longint c = cyc;
            automatic int nxt = ms;
            automatic logic st_ep = 1'b0, ov = 1'b0, lost = 1'b0, any_h = 1'b0;
            automatic logic edge_t = bus.trigger && !mprev;
            automatic logic remain = mm == 2 || (mm == 1 && mep < mbc);
            for (int i = 0; i < CC; i++) if (hi(i, c)) any_h = 1'b1;
            if (ms != 0 && bus.disarm) nxt = 0;
            else if ((ms == 2 || ms == 3) && !bus.bsync_ready) begin nxt = 0; lost = 1'b1; end
            else if (ms == 1 && !bus.bsync_ready) nxt = 0;
            else begin
                case (ms)
                    0: if (bus.arm && bus.bsync_ready) begin
                        nxt = 1; mm = bus.mode; mbc = int'(bus.burst_count); mpw = int'(bus.pulse_width);
                        men = bus.ch_en;
                        for (int i = 0; i < CC; i++) mph[i] = int'(bus.ch_phase[i*PHW +: PHW]);
                    end
                    1: if (edge_t) begin nxt = 2; mts = mts_cnt; end
                    2: if (bus.bsync) begin nxt = 3; st_ep = 1'b1; mep = 0; end
                    3: if (pend == '0 && !any_h && (!remain || men == '0)) nxt = 4;
                       else if (bus.bsync && remain) begin st_ep = 1'b1; ov = pend != '0; mep++; end
                    default: nxt = 0;
                endcase
            end
            if (st_ep) begin t_ep = c; pend = men; end
            if (nxt == 3) begin
                for (int i = 0; i < CC; i++)
                    if (pend[i] && c == t_ep + mph[i]) begin rise[i] = c + 1; pend[i] = 1'b0; end
            end else begin
                pend = '0;
                for (int i = 0; i < CC; i++) rise[i] = -1;
            end
            if (bus.bsync) mts_cnt++;
            mprev = bus.trigger;
            mov = ov || (mov && !bus.err_clear);
            msl = lost || (msl && !bus.err_clear);
            ms = nxt;
            e_state = 3'(nxt); e_busy = nxt != 0; e_done = nxt == 4; e_ov = mov; e_sl = msl;
            for (int i = 0; i < CC; i++) e_trig[i] = hi(i, c + 1);
            cyc++;
        end
    end

    // per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (rstn) begin
            automatic logic [CC+6:0] got = {bus.trig_out, bus.state, bus.busy, bus.done, bus.overrun_err, bus.sync_lost_err};
            automatic logic [CC+6:0] exp = {e_trig, e_state, e_busy, e_done, e_ov, e_sl};
            checks++;
            if (got !== exp) begin
                errors++;
                if (nprint < 20) $display("FAIL cycle_model cyc=%0d got=%b expected=%b", cyc, got, exp);
                nprint++;
            end
`ifdef TRIGGER_CHANNEL_BANK_TIMESTAMP_EN
            checks++;
            if (ts !== mts) begin
                errors++;
                if (nprint < 20) $display("FAIL timestamp_model got=%0d expected=%0d", ts, mts);
                nprint++;
            end
`endif
        end
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] m, input int bc, input int pw, input logic [CC-1:0] en,
                       input int p0, input int p1, input int p2, input int p3);
        bus.mode = m; bus.burst_count = BW'(bc); bus.pulse_width = PWW'(pw); bus.ch_en = en;
        bus.ch_phase = {PHW'(p3), PHW'(p2), PHW'(p1), PHW'(p0)};
    endtask

    task automatic arm_and_trigger();
        bus.trigger = 1'b0; tick();
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        bus.trigger = 1'b1; tick();
    endtask

    initial begin
        logic [20:0] v0, v2, v13, vd;
        logic [2:0] st1, st16;
        int n, nd, bad, w;
        bus.bsync = 1'b0; bus.bsync_ready = 1'b1; bus.trigger = 1'b0; bus.arm = 1'b0; bus.disarm = 1'b0;
        bus.err_clear = 1'b0;
        cfg(2'd0, 0, 0, '0, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset_outputs", {bus.trig_out, bus.state, bus.busy, bus.done, bus.overrun_err, bus.sync_lost_err}, 0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // single mode, two channels, preceded by 7 ignored bsyncs in ARMED
        cfg(2'd0, 0, 1, 4'b0101, 3, 0, 10, 0);
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        chk("single_armed", bus.state, 1);
        repeat (7) begin bus.bsync = 1'b1; tick(); bus.bsync = 1'b0; tick(); end
        bus.trigger = 1'b1; tick();
        chk("single_wait", bus.state, 2);
`ifdef TRIGGER_CHANNEL_BANK_TIMESTAMP_EN
        chk("timestamp_7", ts, 7);
`endif
        bus.bsync = 1'b1; tick(); bus.bsync = 1'b0;
        v0 = '0; v2 = '0; v13 = '0; vd = '0; st1 = '0; st16 = '1;
        for (int k = 1; k <= 20; k++) begin
            v0[k] = bus.trig_out[0]; v2[k] = bus.trig_out[2];
            v13[k] = bus.trig_out[1] | bus.trig_out[3]; vd[k] = bus.done;
            if (k == 1) st1 = bus.state;
            if (k == 16) st16 = bus.state;
            tick();
        end
        chk("single_run_state", st1, 3);
        chk("single_ch0_window", v0, 21'h30);
        chk("single_ch2_window", v2, 21'h1800);
        chk("single_ch13_quiet", v13, 0);
        chk("single_done_once", vd, 21'h4000);
        chk("single_idle_after", st16, 0);

        // burst of 3 epochs, bsync period 64, phase 5
        cfg(2'd1, 2, 0, 4'b0001, 5, 0, 0, 0);
        arm_and_trigger();
        n = 0; nd = 0; bad = 0;
        for (int b = 0; b < 4; b++) begin
            bus.bsync = 1'b1; tick(); bus.bsync = 1'b0;
            for (int j = 1; j < 64; j++) begin
                if (bus.trig_out[0]) begin n++; if (j != 6) bad++; end
                if (bus.done) nd++;
                tick();
            end
        end
        chk("burst_pulses", n, 3);
        chk("burst_offset", bad, 0);
        chk("burst_done", nd, 1);

        // overrun: phase 100 never reached within a 64-cycle epoch
        cfg(2'd1, 2, 0, 4'b0001, 100, 0, 0, 0);
        arm_and_trigger();
        bus.bsync = 1'b1; tick(); bus.bsync = 1'b0;
        n = 0;
        repeat (63) begin n += int'(bus.trig_out[0]); tick(); end
        chk("overrun_before", bus.overrun_err, 0);
        bus.bsync = 1'b1; tick(); bus.bsync = 1'b0;
        chk("overrun_set", bus.overrun_err, 1);
        repeat (63) begin n += int'(bus.trig_out[0]); tick(); end
        chk("overrun_no_fire", n, 0);
        bus.bsync = 1'b1; tick(); bus.bsync = 1'b0;
        w = 0;
        while (!bus.done && w < 200) begin n += int'(bus.trig_out[0]); tick(); w++; end
        chk("overrun_done_seen", bus.done, 1);
        chk("overrun_final_fire", n, 1);
        bus.err_clear = 1'b1; tick(); bus.err_clear = 1'b0;
        chk("overrun_cleared", bus.overrun_err, 0);

        // bsync_ready loss mid-pulse
        cfg(2'd0, 0, 15, 4'b0001, 0, 0, 0, 0);
        arm_and_trigger();
        bus.bsync = 1'b1; tick(); bus.bsync = 1'b0;
        chk("abort_pulse_high", bus.trig_out[0], 1);
        tick(); tick();
        bus.bsync_ready = 1'b0; tick(); bus.bsync_ready = 1'b1;
        chk("abort_trig_low", bus.trig_out, 0);
        chk("abort_sync_lost", bus.sync_lost_err, 1);
        chk("abort_state", bus.state, 0);
        chk("abort_no_done", bus.done, 0);
        bus.err_clear = 1'b1; tick(); bus.err_clear = 1'b0;

        // disarm in ARMED, arm without bsync_ready, trigger held high across arm
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        bus.disarm = 1'b1; tick(); bus.disarm = 1'b0;
        chk("disarm_armed_state", bus.state, 0);
        chk("disarm_armed_no_err", bus.sync_lost_err, 0);
        bus.bsync_ready = 1'b0; bus.arm = 1'b1; tick(); bus.arm = 1'b0; bus.bsync_ready = 1'b1;
        chk("arm_not_ready", bus.state, 0);
        bus.trigger = 1'b1; tick();
        bus.arm = 1'b1; tick(); bus.arm = 1'b0;
        repeat (5) tick();
        chk("held_trigger_ignored", bus.state, 1);
        bus.trigger = 1'b0; tick(); bus.trigger = 1'b1; tick();
        chk("retrigger_accepted", bus.state, 2);
        bus.disarm = 1'b1; tick(); bus.disarm = 1'b0;

        // continuous mode: 10 epochs then disarm
        cfg(2'd2, 0, 0, 4'b0001, 2, 0, 0, 0);
        arm_and_trigger();
        n = 0; nd = 0;
        for (int b = 0; b < 10; b++) begin
            bus.bsync = 1'b1; tick(); bus.bsync = 1'b0;
            for (int j = 1; j < 20; j++) begin
                n += int'(bus.trig_out[0]); nd += int'(bus.done); tick();
            end
        end
        chk("cont_pulses", n, 10);
        chk("cont_still_run", bus.state, 3);
        bus.disarm = 1'b1; tick(); bus.disarm = 1'b0;
        chk("cont_disarm_state", bus.state, 0);
        chk("cont_no_done", nd + int'(bus.done), 0);

        // randomized traffic, checked cycle by cycle against the model
        begin
            int period = 32;
            for (int c = 0; c < 6000; c++) begin
                if (c % 200 == 0) begin
                    cfg(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 7), CC'($urandom),
                        $urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 50), $urandom_range(0, 50));
                    period = $urandom_range(16, 70);
                end
                bus.bsync = c % period == 0;
                bus.arm = $urandom_range(0, 15) == 0;
                if ($urandom_range(0, 5) == 0) bus.trigger = ~bus.trigger;
                bus.disarm = $urandom_range(0, 255) == 0;
                bus.bsync_ready = $urandom_range(0, 299) != 0;
                bus.err_clear = $urandom_range(0, 63) == 0;
                tick();
            end
        end
        bus.bsync = 1'b0; bus.arm = 1'b0; bus.disarm = 1'b1; bus.bsync_ready = 1'b1; bus.err_clear = 1'b0;
        tick(); bus.disarm = 1'b0;
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/trigger_channel_bank.md
Name: trigger_channel_bank

Overview:
Multi-channel, BSYNC-aligned trigger generator that replaces the single-shot per-channel trigger instances in the ADF4030 sync core. It arms on command, waits for an external trigger edge, then aligns to the next BSYNC pulse and fires one phase-offset pulse per enabled channel. It supports single, burst and continuous modes and reports overrun and sync-loss errors. It sits between the bsync generator and the regmap, in the device_clk domain.

Parameters:
CHANNEL_COUNT, 4, number of trigger outputs (1..32)
PHASE_WIDTH, 16, width of per-channel phase offset in clk cycles
BURST_WIDTH, 8, width of burst epoch count
PW_WIDTH, 4, width of pulse-width field

Ports:
clk  in  1  device clock; all logic on rising edge
rstn  in  1  asynchronous active-low reset
bsync  in  1  single-cycle BSYNC pulse, already in clk domain
bsync_ready  in  1  BSYNC generator locked
trigger  in  1  synchronised trigger level; rising edge used
arm  in  1  single-cycle arm request
disarm  in  1  single-cycle abort request
mode  in  2  0 single, 1 burst, 2 continuous, 3 = single
burst_count  in  BURST_WIDTH  epochs minus 1 (burst mode)
pulse_width  in  PW_WIDTH  high time minus 1
ch_en  in  CHANNEL_COUNT  channel enables
ch_phase  in  CHANNEL_COUNT*PHASE_WIDTH  flattened phases; channel i at [i*PHASE_WIDTH +: PHASE_WIDTH]
err_clear  in  1  clears sticky errors
trig_out  out  CHANNEL_COUNT  trigger pulses
state  out  3  FSM state encoding
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
overrun_err  out  1  sticky overrun error
sync_lost_err  out  1  sticky BSYNC-loss error

Behaviour:
- Reset: all outputs 0, state IDLE; counters, snapshots and trigger edge register cleared.
- All outputs are registered.
- States: IDLE=0, ARMED=1, WAIT_BSYNC=2, RUN=3, DONE=4.
- IDLE: arm with bsync_ready=1 moves to ARMED and snapshots mode, burst_count, pulse_width, ch_en and ch_phase. arm with bsync_ready=0 is ignored.
- Configuration inputs are not sampled after the snapshot until the next arm.
- ARMED: trigger rising edge (trigger=1, previous sample=0) moves to WAIT_BSYNC. A bsync in the same cycle is not used.
- WAIT_BSYNC: bsync moves to RUN and starts epoch 0. All channel counters load 0 and the epoch counter loads 0.
- RUN, per epoch: each enabled channel counts clk cycles from the cycle after the bsync.
  - For a bsync sampled at cycle T, channel i rises at T+1+phase_i and stays high pulse_width+1 cycles.
  - Each channel fires at most once per epoch.
- New epoch: a bsync in RUN while epochs remain starts a new epoch and restarts the channel counters.
  - Any enabled channel that has not yet fired in the old epoch sets overrun_err; its pending fire is discarded.
  - A pulse already high continues to completion. If the channel re-fires while high, its width counter restarts.
- Epochs remaining:
  - single: none after epoch 0.
  - burst: until epoch count = burst_count.
  - continuous: always; it exits only on disarm.
- After the final epoch, further bsync is ignored.
- When every enabled channel has fired and all trig_out are low, the FSM moves to DONE.
- No enabled channels: RUN exits after 1 cycle.
- DONE: done=1 for one cycle, then IDLE.
- disarm in any non-IDLE state: next cycle state is IDLE, trig_out=0, no done pulse. disarm has priority over every other event in the same cycle.
- bsync_ready=0 in WAIT_BSYNC or RUN: abort as for disarm and set sync_lost_err. In ARMED it only returns to IDLE, without setting the error.
- arm while not IDLE is ignored.
- Errors: a set event in the same cycle as err_clear wins; the error is cleared otherwise.
- Counters saturate at their maximum and never wrap.
- Epoch counter arithmetic is BURST_WIDTH+1 bits.

Optional Feature:
TRIGGER_CHANNEL_BANK_TIMESTAMP_EN
- Defined: adds output trig_timestamp[31:0] and a free-running 32-bit bsync counter.
  - The counter resets to 0 on rstn, increments on every bsync and wraps at 2^32.
  - The counter value is latched into trig_timestamp in the cycle the trigger edge is accepted in ARMED.
  - trig_timestamp holds until the next accepted trigger and resets to 0.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Single mode; ch_en=4'b0101, phase ch0=3, ch2=10, pulse_width=1; arm, trigger edge, bsync at cycle T -> trig_out[0] high at T+4..T+5, trig_out[2] high at T+11..T+12, channels 1 and 3 stay low, done pulses once after T+12, state returns to 0.
- Burst mode, burst_count=2, bsync period 64, phase 5 -> exactly 3 pulses at each bsync+6, then done and no pulse on the 4th bsync.
- Overrun: phase=100, bsync period 64 in burst mode -> overrun_err=1 from the second bsync and channel not fired in epoch 0; err_clear then clears it.
- Abort: drop bsync_ready mid-RUN with a pulse high -> trig_out=0 the next cycle, sync_lost_err=1, no done, state=0; separately, disarm in ARMED -> IDLE, no error.
- Edge cases: arm with bsync_ready=0 is ignored; trigger held high before arm does not trigger until it falls and rises again; continuous mode runs 10 epochs then stops on disarm.
- With TRIGGER_CHANNEL_BANK_TIMESTAMP_EN defined: 7 bsyncs before the trigger edge -> trig_timestamp=7.
